// File: rtl/fighter_pkg.sv
// Shared encodings for the fighter controller and its combo detector.
package fighter_pkg;

  typedef enum logic [2:0] {
    STATE_NORMAL  = 3'b000,
    STATE_PUNCH   = 3'b001,
    STATE_SP_0    = 3'b010,
    STATE_INJURED = 3'b100
  } char_state_t;

  typedef enum logic [1:0] {
    MOVE_IDLE   = 2'b00,
    MOVE_TOWARD = 2'b01,
    MOVE_AWAY   = 2'b10
  } move_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_D    = 2'd2,
    DIR_R    = 2'd3
  } combo_dir_t;

  // Events captured between frame ticks, consumed together at the tick.
  typedef struct packed {
    logic up;
    logic down;
    logic attack;
    logic left;
    logic right;
    logic hit;
  } pend_t;

  localparam logic [5:0] COMBO_SEQ = {DIR_L, DIR_D, DIR_R};

endpackage

// File: rtl/fighter_controller_combo.sv
// Combo detector: three-entry history of direction edges, expired after a
// configurable number of idle frame ticks.
module combo_detector
  import fighter_pkg::*;
#(
  parameter int unsigned COMBO_TICKS = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic edge_l,
  input  logic edge_d,
  input  logic edge_r,
  input  logic clear,
  output logic combo_match
);

  localparam int GAP_W = $clog2(COMBO_TICKS + 1);

  logic [2:0][1:0]  hist_q;
  logic [2:0][1:0]  hist_d;
  logic [GAP_W-1:0] gap_q;
  logic             push;

  // Simultaneous edges are pushed in L, D, R order; entry 2 is the oldest.
  always_comb begin
    hist_d = hist_q;
    if (edge_l) hist_d = {hist_d[1:0], DIR_L};
    if (edge_d) hist_d = {hist_d[1:0], DIR_D};
    if (edge_r) hist_d = {hist_d[1:0], DIR_R};
  end

  assign push = tick & (edge_l | edge_d | edge_r);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      gap_q  <= '0;
    end else if (push) begin
      hist_q <= hist_d;
      gap_q  <= GAP_W'(COMBO_TICKS);
    end else if (tick && gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
      if (gap_q == GAP_W'(1)) hist_q <= '0;
    end
  end

  assign combo_match = (hist_q == COMBO_SEQ);

endmodule

// File: rtl/fighter_controller.sv
// Per-player fighter controller: frame-tick physics, facing and attack/injury
// state for the sprite renderer.
module fighter_controller
  import fighter_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1_666_666,
  parameter int unsigned X_MIN       = 16,
  parameter int unsigned X_MAX       = 80,
  parameter int unsigned X_START     = 24,
  parameter int unsigned GROUND_Y    = 40,
  parameter int unsigned STEP        = 1,
  parameter int unsigned JUMP_V      = 6,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned PUNCH_TICKS = 23,
  parameter int unsigned SP_TICKS    = 34,
  parameter int unsigned INJ_TICKS   = 23,
  parameter int unsigned COMBO_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit,
  input  logic [6:0] opponent_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMR_W = 8;
  localparam logic signed [8:0] GROUND_S = 9'(GROUND_Y);
  localparam logic signed [7:0] JUMP_S   = 8'(JUMP_V);
  localparam logic signed [7:0] GRAV_S   = 8'(GRAVITY);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             up_q, down_q, attack_q, left_q, right_q;
  pend_t            pend_q, pend;
  char_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             in_normal, attack_go, jump_go, combo_clear, combo_match;
  logic [7:0]       x_inc;
  logic [6:0]       x_d;
  move_state_t      move_d;
  logic signed [7:0] vy_q, vy_eff;
  logic signed [8:0] y_next;
  logic             air_eff, land;

  // Tick is registered, so frame updates land one clk after the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= CNT_W'(TICK_DIV - 1);
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == '0);
      tick_cnt <= (tick_cnt == '0) ? CNT_W'(TICK_DIV - 1) : tick_cnt - 1'b1;
    end
  end

  // Edges arriving on the tick clk itself are folded in before consumption.
  always_comb begin
    pend        = pend_q;
    pend.up     = pend_q.up     | (btn_up     & ~up_q);
    pend.down   = pend_q.down   | (btn_down   & ~down_q);
    pend.attack = pend_q.attack | (btn_attack & ~attack_q);
    pend.left   = pend_q.left   | (btn_left   & ~left_q);
    pend.right  = pend_q.right  | (btn_right  & ~right_q);
    pend.hit    = pend_q.hit    | hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {up_q, down_q, attack_q, left_q, right_q} <= '0;
      pend_q <= '0;
      mirror <= 1'b0;
    end else begin
      {up_q, down_q, attack_q, left_q, right_q} <=
        {btn_up, btn_down, btn_attack, btn_left, btn_right};
      pend_q <= tick ? '0 : pend;
      mirror <= (opponent_x < x);
    end
  end

  combo_detector #(.COMBO_TICKS(COMBO_TICKS)) u_combo (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .edge_l      (pend.left),
    .edge_d      (pend.down),
    .edge_r      (pend.right),
    .clear       (combo_clear),
    .combo_match (combo_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_NORMAL;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (tick) begin
      if (pend.hit) begin
        state_d = STATE_INJURED;
        timer_d = TMR_W'(INJ_TICKS);
      end else if (state_q == STATE_NORMAL) begin
        if (pend.attack) begin
          if (combo_match) begin
            state_d = STATE_SP_0;
            timer_d = TMR_W'(SP_TICKS);
          end else begin
            state_d = STATE_PUNCH;
            timer_d = TMR_W'(PUNCH_TICKS);
          end
        end
      end else if (timer_q == TMR_W'(1)) begin
        state_d = STATE_NORMAL;
        timer_d = '0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_comb begin
    in_normal   = (state_q == STATE_NORMAL);
    attack_go   = tick & in_normal & pend.attack & ~pend.hit;
    jump_go     = tick & in_normal & pend.up & ~pend.attack & ~pend.hit & ~in_air;
    combo_clear = tick & (pend.hit | (attack_go & combo_match));
  end

  assign character_state = state_q;

  always_comb begin
    x_d    = x;
    move_d = MOVE_IDLE;
    x_inc  = {1'b0, x} + 8'(STEP);
    if (in_normal && (btn_left != btn_right)) begin
      if (btn_left) begin
        x_d    = ({1'b0, x} >= 8'(X_MIN + STEP)) ? x - 7'(STEP) : 7'(X_MIN);
        move_d = mirror ? MOVE_TOWARD : MOVE_AWAY;
      end else begin
        x_d    = (x_inc <= 8'(X_MAX)) ? x_inc[6:0] : 7'(X_MAX);
        move_d = mirror ? MOVE_AWAY : MOVE_TOWARD;
      end
    end
  end

  // The jump tick already takes its first step using the launch velocity.
  always_comb begin
    vy_eff  = jump_go ? JUMP_S : vy_q;
    air_eff = in_air | jump_go;
    y_next  = $signed({2'b00, y}) - $signed({vy_eff[7], vy_eff});
    land    = vy_eff[7] && (y_next >= GROUND_S);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= 7'(X_START);
      y          <= 7'(GROUND_Y);
      in_air     <= 1'b0;
      vy_q       <= '0;
      move_state <= MOVE_IDLE;
    end else if (tick) begin
      x          <= x_d;
      move_state <= move_d;
      if (air_eff) begin
        if (land) begin
          y      <= 7'(GROUND_Y);
          in_air <= 1'b0;
          vy_q   <= '0;
        end else begin
          y      <= y_next[6:0];
          in_air <= 1'b1;
          vy_q   <= vy_eff - GRAV_S;
        end
      end
    end
  end

endmodule

// File: tb/tb_fighter_controller.sv
// Scoreboard bench for fighter_controller: a frame-level reference model
// predicts every clk's outputs; a monitor compares them against the DUT.
module tb_fighter_controller;

  localparam int TD = 4, XMIN = 16, XMAX = 80, XST = 24, GY = 40, STEP = 1;
  localparam int JV = 6, G = 1, PT = 23, ST = 34, IT = 23, CT = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0, btn_attack = 0, hit = 0;
  logic [6:0] opponent_x = 7'd70;
  logic [6:0] x, y;
  logic       in_air, mirror;
  logic [1:0] move_state;
  logic [2:0] character_state;

  fighter_controller #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .btn_attack(btn_attack), .hit(hit),
    .opponent_x(opponent_x), .x(x), .y(y), .in_air(in_air),
    .move_state(move_state), .character_state(character_state), .mirror(mirror)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int air; int mv; int cs; int mir; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int cnt_p = 0, cnt_s = 0, cnt_i = 0, min_y = 127;

  // Reference model state: frame index, ticks when timed states end, jump age.
  int m_x, m_y, m_air_t, m_mv, m_cs, m_mir, m_end, m_e, m_tick, m_last_push;
  bit p_up, p_dn, p_at, p_hit, p_l, p_r;
  bit q_up, q_dn, q_at, q_l, q_r;
  int cq[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic void model_tick();
    int  old_cs, t, h, yn;
    bit  match, clr, att_go, jump;
    old_cs = m_cs;
    clr = 0; att_go = 0;
    m_tick++;
    match = (cq.size() == 3 && cq[0] == 1 && cq[1] == 2 && cq[2] == 3);
    if (p_hit) begin
      m_cs = 4; m_end = m_tick + IT; clr = 1;
    end else if (old_cs == 0 && p_at) begin
      att_go = 1;
      if (match) begin m_cs = 2; m_end = m_tick + ST; clr = 1; end
      else begin m_cs = 1; m_end = m_tick + PT; end
    end else if (old_cs != 0 && m_tick == m_end) begin
      m_cs = 0;
    end
    m_mv = 0;
    if (old_cs == 0 && btn_left != btn_right) begin
      if (btn_left) begin
        m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
        m_mv = m_mir ? 1 : 2;
      end else begin
        m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
        m_mv = m_mir ? 2 : 1;
      end
    end
    jump = p_up && m_air_t == 0 && old_cs == 0 && !p_hit && !att_go;
    if (jump || m_air_t > 0) begin
      t  = m_air_t + 1;
      h  = t * JV - G * t * (t - 1) / 2;
      yn = GY - h;
      if ((JV - (t - 1) * G) < 0 && yn >= GY) begin m_y = GY; m_air_t = 0; end
      else begin m_y = yn; m_air_t = t; end
    end
    if (clr) cq.delete();
    else begin
      if (p_l) cq.push_back(1);
      if (p_dn) cq.push_back(2);
      if (p_r) cq.push_back(3);
      while (cq.size() > 3) void'(cq.pop_front());
      if (p_l || p_dn || p_r) m_last_push = m_tick;
      else if (cq.size() > 0 && m_tick - m_last_push == CT) cq.delete();
    end
    {p_up, p_dn, p_at, p_hit, p_l, p_r} = '0;
  endfunction

  function automatic void model_step();
    exp_t e;
    int   nx_mir;
    if (reset) begin
      m_x = XST; m_y = GY; m_air_t = 0; m_mv = 0; m_cs = 0; m_mir = 0;
      m_end = 0; m_e = 0; m_tick = 0; m_last_push = 0;
      {p_up, p_dn, p_at, p_hit, p_l, p_r} = '0;
      {q_up, q_dn, q_at, q_l, q_r} = '0;
      cq.delete();
    end else begin
      m_e++;
      p_up  |= btn_up & !q_up;
      p_dn  |= btn_down & !q_dn;
      p_at  |= btn_attack & !q_at;
      p_l   |= btn_left & !q_l;
      p_r   |= btn_right & !q_r;
      p_hit |= hit;
      {q_up, q_dn, q_at, q_l, q_r} = {btn_up, btn_down, btn_attack, btn_left, btn_right};
      nx_mir = (int'(opponent_x) < m_x) ? 1 : 0;
      if (m_e > TD && (m_e - 1) % TD == 0) model_tick();
      m_mir = nx_mir;
    end
    e.x = m_x; e.y = m_y; e.air = (m_air_t > 0) ? 1 : 0;
    e.mv = m_mv; e.cs = m_cs; e.mir = m_mir;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic ticks(input int n);
    cyc(n * TD);
  endtask

  task automatic do_combo(input int g1, input int g2, input int g3);
    btn_left = 1;   cyc(1); btn_left = 0;   cyc(g1 * TD - 1);
    btn_down = 1;   cyc(1); btn_down = 0;   cyc(g2 * TD - 1);
    btn_right = 1;  cyc(1); btn_right = 0;  cyc(g3 * TD - 1);
    btn_attack = 1; cyc(1); btn_attack = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (character_state == 3'b001) cnt_p++;
      if (character_state == 3'b010) cnt_s++;
      if (character_state == 3'b100) cnt_i++;
      if (int'(y) < min_y) min_y = int'(y);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x", int'(x), e.x);
        chk("y", int'(y), e.y);
        chk("in_air", int'(in_air), e.air);
        chk("move_state", int'(move_state), e.mv);
        chk("character_state", int'(character_state), e.cs);
        chk("mirror", int'(mirror), e.mir);
      end
    end
  end

  initial begin : driver
    cyc(3);
    reset = 0;
    btn_right = 1; ticks(3);
    btn_right = 0; ticks(2);
    btn_right = 1; ticks(60);
    opponent_x = 7'd10; cyc(1); ticks(2);
    btn_right = 0; ticks(1);

    min_y = 127;
    cyc(2); btn_up = 1; cyc(1); btn_up = 0;
    ticks(4);
    btn_up = 1; cyc(1); btn_up = 0;
    ticks(12);
    chk("jump_peak_y", min_y, 19);

    cnt_p = 0;
    btn_attack = 1; cyc(1); btn_attack = 0;
    ticks(10);
    btn_attack = 1; cyc(1); btn_attack = 0;
    btn_left = 1; ticks(5); btn_left = 0;
    ticks(15);
    chk("punch_clks", cnt_p, PT * TD);

    cnt_s = 0;
    do_combo(5, 5, 5); ticks(45);
    chk("sp0_clks", cnt_s, ST * TD);

    cnt_s = 0; cnt_p = 0;
    do_combo(5, 31, 5); ticks(30);
    chk("late_combo_sp_clks", cnt_s, 0);
    chk("late_combo_punch_clks", cnt_p, PT * TD);

    do_combo(3, 4, 2); ticks(5);
    cnt_i = 0;
    hit = 1; btn_attack = 1; cyc(1); hit = 0; btn_attack = 0;
    cyc(10 * TD - 1);
    hit = 1; cyc(1); hit = 0;
    ticks(40);
    chk("injured_clks", cnt_i, 33 * TD);

    btn_up = 1; cyc(1); btn_up = 0; ticks(3);
    reset = 1; cyc(1); reset = 0; ticks(2);

    opponent_x = 7'd90;
    btn_left = 1; ticks(15); btn_left = 0; ticks(1);

    for (int k = 0; k < 8; k++) begin
      do_combo($urandom_range(1, 6), $urandom_range(26, 33), $urandom_range(1, 4));
      ticks($urandom_range(36, 40));
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 19) == 0) btn_right = ~btn_right;
      btn_up     = ($urandom_range(0, 29) == 0);
      btn_down   = ($urandom_range(0, 9) == 0);
      btn_attack = ($urandom_range(0, 39) == 0);
      hit        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) opponent_x = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 99) == 0) opponent_x = 7'(m_x);
      reset = ($urandom_range(0, 1499) == 0);
      cyc(1);
    end
    reset = 0;
    cyc(2);
    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fighter_controller.md
Name: fighter_controller

Overview:
Per-player character controller: turns debounced button levels and a hit strobe into position, facing and animation state for the sprite renderer. Outputs feed the renderer's x, y, in_air, move_state, character_state and mirror inputs directly. Physics and timing advance on an internal frame tick. Combo (left > down > right > attack) detection is in a sub-module.

Parameters:
TICK_DIV, 1_666_666, clk cycles per frame tick (60 Hz at 100 MHz; benches use 4)
X_MIN, 16, left clamp for x
X_MAX, 80, right clamp for x
X_START, 24, x after reset
GROUND_Y, 40, y when grounded
STEP, 1, horizontal pixels per tick
JUMP_V, 6, initial upward velocity, px/tick
GRAVITY, 1, velocity decrement per tick
PUNCH_TICKS, 23, duration of PUNCH state
SP_TICKS, 34, duration of SP_0 state
INJ_TICKS, 23, duration of INJURED state
COMBO_TICKS, 30, max ticks between combo inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn_left  in  1  level, held = move left
btn_right  in  1  level, held = move right
btn_up  in  1  level; rising edge = jump
btn_down  in  1  level; rising edge = combo input only
btn_attack  in  1  level; rising edge = attack
hit  in  1  one-clk strobe, opponent attack connected
opponent_x  in  7  opponent x, for facing
x  out  7  sprite centre x
y  out  7  sprite centre y
in_air  out  1  airborne flag
move_state  out  2  00 idle, 01 toward opponent, 10 away
character_state  out  3  000 NORMAL, 001 PUNCH, 010 SP_0, 100 INJURED
mirror  out  1  1 = facing left

Behaviour:
- Clock is clk. Reset is synchronous, active-high. Reset values: x=X_START, y=GROUND_Y, in_air=0, move_state=00, character_state=000, mirror=0. Tick counter, timers, velocity, pending flags and combo buffer are cleared.
- Tick: a counter 0..TICK_DIV-1 pulses tick for one clk on wrap. All outputs except mirror update on the clk after tick (latency 1 clk).
- Edge capture: rising edges of up, down and attack, and hit strobes, are detected every clk. Each sets a pending flag. All flags are consumed and cleared at the next tick. Edges between ticks are never lost. Duplicates collapse into one.
- mirror is combinational-registered every clk: mirror = (opponent_x < x). Equal values give 0.
- Horizontal movement applies only in NORMAL, grounded or airborne:
  - left only: x = max(x-STEP, X_MIN).
  - right only: x = min(x+STEP, X_MAX).
  - both or neither: x unchanged.
- move_state:
  - 01 if moving toward opponent (right with mirror=0, or left with mirror=1).
  - 10 if moving away.
  - 00 if not moving or not NORMAL.
  - When clamped at a limit, x stays put and move_state still reflects the held direction.
- Jump: up edge while grounded and in NORMAL sets in_air=1 and vy=JUMP_V (signed 8-bit internal).
  - Each airborne tick: y_next = y - vy, then vy -= GRAVITY.
  - If vy<0 and y_next >= GROUND_Y: y=GROUND_Y, in_air=0, vy=0.
  - Gravity continues in every state, so a hit mid-air still lands.
  - With default parameters the jump peaks at y=19 and lands after exactly 13 ticks.
- State machine, evaluated at tick, priority high to low:
  1. hit pending: go to INJURED with timer=INJ_TICKS from any state, including INJURED (restart). Cancels attacks and clears the combo buffer.
  2. In NORMAL with attack pending:
     - combo_match=1: go to SP_0 with timer=SP_TICKS, and clear the buffer.
     - otherwise: go to PUNCH with timer=PUNCH_TICKS.
  3. In PUNCH, SP_0 or INJURED: decrement timer; at 1, go to NORMAL on that tick. Attack and up edges during these states are discarded.
- Combo buffer: a 3-entry shift register of direction edge codes L, D, R.
  - Left and right edges come from the held levels; down from its edge.
  - A gap counter resets on each push. Reaching COMBO_TICKS clears the buffer.
  - combo_match = buffer equals L,D,R, oldest first.
- Same-tick collisions: hit beats attack; attack beats jump (jump ignored when entering PUNCH/SP_0).

Decomposition:
- Shared package fighter_pkg holds:
  - character_state encodings STATE_NORMAL/PUNCH/SP_0/INJURED;
  - move_state encodings;
  - combo direction codes.
- Sub-module combo_detector: edge inputs, tick, clear → combo_match. It owns the buffer and gap counter.

Test Plan:
- Reset, then TICK_DIV=4, opponent_x=70, hold right 3 ticks → x=27, move_state=01, mirror=0. Release right → move_state=00.
- x=X_MAX=80, hold right 5 ticks → x stays 80, move_state=01. Set opponent_x=10 → mirror=1 next clk, move_state=10.
- Pulse up for 1 clk mid-tick → in_air=1 after next tick, y=34. Minimum y=19. After 13 ticks y=40, in_air=0. A second up while in_air has no effect.
- Attack edge → character_state=001 for exactly 23 ticks, then 000. Attack again at tick 10 → ignored. Hold left during PUNCH → x unchanged, move_state=00.
- Edges left, down, right, attack, 5 ticks apart → character_state=010 for 34 ticks. Repeat with a 31-tick gap before right → 001 instead.
- Hit strobe during SP_0 and simultaneous with an attack edge → 100 on next tick. Second hit at tick 10 → timer restarts, INJURED lasts 33 ticks total. Reset asserted mid-jump → y=40, in_air=0, state=000 on next clk.
